// File: rtl/centered_inverse_similarity_transform.sv
// rtl/centered_inverse_similarity_transform.sv - re-applies stored f sign flips to projected vectors
module centered_inverse_similarity_transform #(
  parameter int TAG_WIDTH   = 32,
  parameter int BLOCKLENGTH = 1,
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              f_valid,
  input  logic [0:BLOCKLENGTH-1]            f_in,
  output logic                              f_ready,
  input  logic                              valid_in,
  input  logic [TAG_WIDTH-1:0]              tag_in,
  input  logic [DATA_WIDTH*BLOCKLENGTH-1:0] data_in,
  output logic                              ready_out,
  input  logic                              ready_in,
  output logic                              valid_out,
  output logic [TAG_WIDTH-1:0]              tag_out,
  output logic [DATA_WIDTH*BLOCKLENGTH-1:0] data_out,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH):0]       f_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] MOST_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  logic [0:BLOCKLENGTH-1]            f_mem [0:FIFO_DEPTH-1];
  logic [PTR_W-1:0]                  wr_ptr;
  logic [PTR_W-1:0]                  rd_ptr;
  logic [CNT_W-1:0]                  count;

  logic                              v0;
  logic                              v1;
  logic [DATA_WIDTH*BLOCKLENGTH-1:0] d0;
  logic [0:BLOCKLENGTH-1]            f0;
  logic [TAG_WIDTH-1:0]              t0;
  logic [DATA_WIDTH*BLOCKLENGTH-1:0] d1;
  logic [TAG_WIDTH-1:0]              t1;

  logic                              enable;
  logic                              push;
  logic                              accept;
  logic [DATA_WIDTH*BLOCKLENGTH-1:0] xform;
  logic [DATA_WIDTH-1:0]             comp;

  // Handshake decode; a data beat never bypasses an empty FIFO.
  assign enable    = !v1 || ready_in;
  assign f_ready   = (count != FULL);
  assign ready_out = enable && (count != '0);
  assign push      = f_valid && f_ready;
  assign accept    = valid_in && ready_out;

  assign valid_out = v1;
  assign tag_out   = t1;
  assign data_out  = d1;
  assign busy      = v0 || v1 || (count != '0);
  assign f_count   = count;

  // f FIFO: circular buffer, pop follows each accepted data beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) f_mem[k] <= '0;
    end else begin
      if (push) begin
        f_mem[wr_ptr] <= f_in;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (accept) rd_ptr <= rd_ptr + 1'b1;
      if (push && !accept)      count <= count + 1'b1;
      else if (!push && accept) count <= count - 1'b1;
    end
  end

  // Per-component conditional negation with saturation of the most negative code.
  always_comb begin
    xform = '0;
    comp  = '0;
    for (int i = 0; i < BLOCKLENGTH; i++) begin
      comp = d0[i*DATA_WIDTH +: DATA_WIDTH];
      if (f0[i]) xform[i*DATA_WIDTH +: DATA_WIDTH] = (comp == MOST_NEG) ? MOST_POS : ({DATA_WIDTH{1'b0}} - comp);
      else       xform[i*DATA_WIDTH +: DATA_WIDTH] = comp;
    end
  end

  // Two-stage pipeline; every stage register holds while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
      d0 <= '0;
      f0 <= '0;
      t0 <= '0;
      d1 <= '0;
      t1 <= '0;
    end else if (enable) begin
      v0 <= accept;
      d0 <= data_in;
      f0 <= f_mem[rd_ptr];
      t0 <= tag_in;
      v1 <= v0;
      d1 <= xform;
      t1 <= t0;
    end
  end

endmodule

// File: tb/tb_centered_inverse_similarity_transform.sv
// tb/tb_centered_inverse_similarity_transform.sv - randomized model-checked bench for the inverse transform
module tb_centered_inverse_similarity_transform;

  localparam int TW = 32;
  localparam int BL = 4;
  localparam int DW = 8;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          f_valid = 1'b0;
  logic [0:BL-1] f_in = '0;
  logic          f_ready;
  logic          valid_in = 1'b0;
  logic [TW-1:0] tag_in = '0;
  logic [31:0]   data_in = '0;
  logic          ready_out;
  logic          ready_in = 1'b1;
  logic          valid_out;
  logic [TW-1:0] tag_out;
  logic [31:0]   data_out;
  logic          busy;
  logic [2:0]    f_count;

  int checks = 0;
  int errors = 0;
  int obs_out = 0;

  typedef struct packed {
    logic        v;
    logic [31:0] data;
    logic [31:0] tag;
  } stage_t;

  logic [0:BL-1] fq[$];
  stage_t p0, p1;

  centered_inverse_similarity_transform #(
    .TAG_WIDTH(TW), .BLOCKLENGTH(BL), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset(reset), .f_valid(f_valid), .f_in(f_in), .f_ready(f_ready),
    .valid_in(valid_in), .tag_in(tag_in), .data_in(data_in), .ready_out(ready_out),
    .ready_in(ready_in), .valid_out(valid_out), .tag_out(tag_out), .data_out(data_out),
    .busy(busy), .f_count(f_count)
  );

  always #5 clk = ~clk;

  // Reference transform: plain integer negation clamped to the 8-bit range.
  function automatic logic [31:0] ref_xf(input logic [0:BL-1] f, input logic [31:0] d);
    logic [31:0] r;
    int v;
    r = '0;
    for (int i = 0; i < BL; i++) begin
      v = int'($signed(d[i*8 +: 8]));
      if (f[i]) v = -v;
      if (v > 127) v = 127;
      r[i*8 +: 8] = v[7:0];
    end
    return r;
  endfunction

  task automatic model_clear();
    fq.delete();
    p0 = '0;
    p1 = '0;
  endtask

  // One clock cycle: compare DUT against the model, then advance both across the edge.
  task automatic step(input string nm);
    bit en, exp_ro, exp_fr, acc, psh;
    #1;
    en     = !p1.v || ready_in;
    exp_ro = en && (fq.size() != 0);
    exp_fr = (fq.size() != FD);
    checks += 5;
    if (ready_out !== exp_ro) begin errors++; $display("FAIL %s ready_out got %b want %b", nm, ready_out, exp_ro); end
    if (f_ready !== exp_fr) begin errors++; $display("FAIL %s f_ready got %b want %b", nm, f_ready, exp_fr); end
    if (valid_out !== p1.v) begin errors++; $display("FAIL %s valid_out got %b want %b", nm, valid_out, p1.v); end
    if (busy !== (p0.v || p1.v || fq.size() != 0)) begin errors++; $display("FAIL %s busy got %b", nm, busy); end
    if (f_count !== 3'(fq.size())) begin errors++; $display("FAIL %s f_count got %0d want %0d", nm, f_count, fq.size()); end
    if (p1.v) begin
      checks += 2;
      if (data_out !== p1.data) begin errors++; $display("FAIL %s data_out got %h want %h", nm, data_out, p1.data); end
      if (tag_out !== p1.tag) begin errors++; $display("FAIL %s tag_out got %h want %h", nm, tag_out, p1.tag); end
    end
    if (valid_out === 1'b1 && ready_in) obs_out++;
    acc = valid_in && exp_ro;
    psh = f_valid && exp_fr;
    if (en) begin
      p1      = p0;
      p0.v    = acc;
      p0.data = acc ? ref_xf(fq[0], data_in) : '0;
      p0.tag  = tag_in;
    end
    if (acc) void'(fq.pop_front());
    if (psh) fq.push_back(f_in);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    f_valid = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
  endtask

  task automatic drain();
    for (int k = 0; k < 30 && (fq.size() != 0 || p0.v || p1.v); k++) begin
      f_valid  = 1'b0;
      ready_in = 1'b1;
      valid_in = (fq.size() != 0);
      data_in  = $urandom;
      tag_in   = $urandom;
      step("drain");
    end
    idle();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL drain busy got %b want 0", busy); end
  endtask

  task automatic check_reset_outputs(input string nm);
    checks += 7;
    if (valid_out !== 1'b0) begin errors++; $display("FAIL %s valid_out got %b want 0", nm, valid_out); end
    if (data_out !== '0) begin errors++; $display("FAIL %s data_out got %h want 0", nm, data_out); end
    if (tag_out !== '0) begin errors++; $display("FAIL %s tag_out got %h want 0", nm, tag_out); end
    if (busy !== 1'b0) begin errors++; $display("FAIL %s busy got %b want 0", nm, busy); end
    if (f_count !== 3'd0) begin errors++; $display("FAIL %s f_count got %0d want 0", nm, f_count); end
    if (f_ready !== 1'b1) begin errors++; $display("FAIL %s f_ready got %b want 1", nm, f_ready); end
    if (ready_out !== 1'b0) begin errors++; $display("FAIL %s ready_out got %b want 0", nm, ready_out); end
  endtask

  task automatic test_reset();
    model_clear();
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("reset_hold");
    @(negedge clk);
    reset = 1'b0;
    #1 check_reset_outputs("reset_release");
    @(negedge clk);
  endtask

  task automatic test_single_beat();
    f_valid = 1'b1; f_in = 4'b1010; valid_in = 1'b0; ready_in = 1'b1;
    step("single_push");
    f_valid = 1'b0; valid_in = 1'b1; tag_in = 32'h11;
    data_in = {8'd0, 8'd127, 8'hFD, 8'd5};
    step("single_data");
    idle();
    step("single_wait");
    #1;
    checks += 4;
    if (valid_out !== 1'b1) begin errors++; $display("FAIL single valid_out got %b want 1", valid_out); end
    if (data_out !== {8'd0, 8'h81, 8'hFD, 8'hFB}) begin errors++; $display("FAIL single data_out got %h want 0081fdfb", data_out); end
    if (tag_out !== 32'h11) begin errors++; $display("FAIL single tag_out got %h want 11", tag_out); end
    if (f_count !== 3'd0) begin errors++; $display("FAIL single f_count got %0d want 0", f_count); end
    drain();
  endtask

  task automatic test_saturation();
    f_valid = 1'b1; f_in = 4'b1111; valid_in = 1'b0;
    step("sat_push");
    f_valid = 1'b0; valid_in = 1'b1; tag_in = 32'h22;
    data_in = {8'd0, 8'd1, 8'hFF, 8'h80};
    step("sat_data");
    idle();
    step("sat_wait");
    #1;
    checks++;
    if (data_out !== {8'd0, 8'hFF, 8'd1, 8'h7F}) begin errors++; $display("FAIL sat data_out got %h want 00ff017f", data_out); end
    drain();
  endtask

  task automatic test_fifo_wrap();
    valid_in = 1'b0; ready_in = 1'b1;
    for (int k = 0; k < 6; k++) begin
      f_valid = 1'b1; f_in = BL'($urandom);
      step("full_push");
    end
    f_valid = 1'b0;
    #1;
    checks += 2;
    if (f_ready !== 1'b0) begin errors++; $display("FAIL full f_ready got %b want 0", f_ready); end
    if (f_count !== 3'd4) begin errors++; $display("FAIL full f_count got %0d want 4", f_count); end
    for (int k = 0; k < 8; k++) begin
      f_valid = 1'b1; f_in = BL'($urandom);
      valid_in = 1'b1; data_in = $urandom; tag_in = 32'h100 + k;
      step("wrap");
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int sent;
    sent = 0;
    obs_out = 0;
    for (int k = 0; k < 12; k++) begin
      f_valid  = (k < 5);
      f_in     = BL'($urandom);
      ready_in = !(k >= 3 && k <= 5);
      valid_in = (sent < 5) && (fq.size() != 0);
      data_in  = $urandom;
      tag_in   = 32'h200 + sent;
      if (valid_in && (!p1.v || ready_in)) sent++;
      step("backpressure");
    end
    drain();
    checks++;
    if (obs_out !== 5) begin errors++; $display("FAIL backpressure beats got %0d want 5", obs_out); end
  endtask

  task automatic test_empty_fifo();
    f_valid = 1'b1; f_in = 4'b0110; valid_in = 1'b1; ready_in = 1'b1;
    data_in = {8'd9, 8'd8, 8'd7, 8'd6}; tag_in = 32'h33;
    #1;
    checks++;
    if (ready_out !== 1'b0) begin errors++; $display("FAIL empty ready_out got %b want 0", ready_out); end
    step("empty_push");
    f_valid = 1'b0;
    step("empty_accept");
    idle();
    step("empty_wait");
    #1;
    checks++;
    if (data_out !== {8'd9, 8'hF8, 8'hF9, 8'd6}) begin errors++; $display("FAIL empty data_out got %h want 09f8f906", data_out); end
    drain();
  endtask

  task automatic test_mid_reset();
    for (int k = 0; k < 4; k++) begin
      f_valid = 1'b1; f_in = BL'($urandom);
      valid_in = 1'b1; data_in = $urandom; tag_in = $urandom; ready_in = 1'b1;
      step("mid_fill");
    end
    reset = 1'b1;
    model_clear();
    #1 check_reset_outputs("mid_reset");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle();
    #1 check_reset_outputs("mid_release");
    valid_in = 1'b1;
    step("mid_no_accept");
    idle();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      f_valid  = ($urandom_range(0, 3) != 0);
      f_in     = BL'($urandom);
      valid_in = ($urandom_range(0, 3) != 0);
      ready_in = ($urandom_range(0, 3) != 0);
      data_in  = $urandom;
      tag_in   = $urandom;
      step("random");
    end
    drain();
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single_beat();
    test_saturation();
    test_fifo_wrap();
    test_back_to_back();
    test_empty_fifo();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
